// File: rtl/ic_pkg.sv
`default_nettype none
// ============================================================================
// ic_pkg -- shared types and default geometry for the I-cache data array
// Revision: 1.0
// ============================================================================
package ic_pkg;

  typedef enum logic [0:0] {
    IMPL_FLOP = 1'b0,
    IMPL_SRAM = 1'b1
  } ic_impl_e;

  localparam int unsigned DEF_WAYS   = 4;
  localparam int unsigned DEF_LINES  = 64;
  localparam int unsigned DEF_WORDS  = 4;
  localparam int unsigned DEF_WORD_W = 16;
  localparam int unsigned DEF_RD_LAT = 1;
  localparam int unsigned DEF_PARITY = 1;

  function automatic bit is_pow2(input int unsigned v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ic_ram_bank.sv
`default_nettype none
// ============================================================================
// ic_ram_bank -- simple dual-port bank: one write port, one registered read
// Revision: 1.0
// ============================================================================
module ic_ram_bank #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 17,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  // Read data holds between reads; same-address write is read-old here.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/ic_data_array.sv
`default_nettype none
// ============================================================================
// ic_data_array -- banked I-cache data array with write-first forwarding
// Revision: 1.0
// ============================================================================
module ic_data_array
  import ic_pkg::*;
#(
  parameter int unsigned WAYS   = DEF_WAYS,
  parameter int unsigned LINES  = DEF_LINES,
  parameter int unsigned WORDS  = DEF_WORDS,
  parameter int unsigned WORD_W = DEF_WORD_W,
  parameter int unsigned RD_LAT = DEF_RD_LAT,
  parameter int unsigned PARITY = DEF_PARITY
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rd_en,
  input  logic [$clog2(WAYS)-1:0]   rd_way,
  input  logic [$clog2(LINES)-1:0]  rd_line,
  input  logic [$clog2(WORDS)-1:0]  rd_word,
  output logic [WORD_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic                      rd_perr,
  input  logic                      wr_en,
  input  logic [$clog2(WAYS)-1:0]   wr_way,
  input  logic [$clog2(LINES)-1:0]  wr_line,
  input  logic [WORDS-1:0]          wr_mask,
  input  logic [WORDS*WORD_W-1:0]   wr_data,
  input  logic                      wr_perr_inj
);

  localparam int unsigned WAY_W  = $clog2(WAYS);
  localparam int unsigned LINE_W = $clog2(LINES);
  localparam int unsigned SEL_W  = $clog2(WORDS);
  localparam int unsigned AW     = LINE_W + WAY_W;
  localparam int unsigned BW     = WORD_W + ((PARITY != 0) ? 1 : 0);

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [AW-1:0]     addr_t;
  typedef logic [SEL_W-1:0]  sel_t;

  if (!is_pow2(WAYS) || !is_pow2(LINES) || !is_pow2(WORDS)) begin : g_bad_geom
    $error("ic_data_array: WAYS, LINES and WORDS must be powers of two >= 2");
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("ic_data_array: RD_LAT must be 1 or 2");
  end

  logic  rd_acc, wr_acc, collide;
  addr_t rd_addr, wr_addr;
  word_t wr_word;

  assign rd_acc  = rd_en & rst_n;
  assign wr_acc  = wr_en & rst_n;
  assign rd_addr = {rd_line, rd_way};
  assign wr_addr = {wr_line, wr_way};
  assign wr_word = wr_data[rd_word*WORD_W +: WORD_W];
  assign collide = rd_acc & wr_acc & (rd_addr == wr_addr) & wr_mask[rd_word];

  word_t            lane_data [WORDS];
  logic [WORDS-1:0] lane_perr;

  for (genvar k = 0; k < WORDS; k++) begin : g_lane
    word_t          lane_wr;
    logic [BW-1:0]  bank_wdata;
    logic [BW-1:0]  bank_rdata;

    assign lane_wr = wr_data[k*WORD_W +: WORD_W];

    if (PARITY != 0) begin : g_par
      // Stored bit is even parity, so XOR over the whole entry flags an error.
      assign bank_wdata   = {(^lane_wr) ^ wr_perr_inj, lane_wr};
      assign lane_perr[k] = ^bank_rdata;
    end else begin : g_nopar
      assign bank_wdata   = lane_wr;
      assign lane_perr[k] = 1'b0;
    end
    assign lane_data[k] = bank_rdata[WORD_W-1:0];

    ic_ram_bank #(
      .DEPTH (WAYS * LINES),
      .WIDTH (BW),
      .AW    (AW)
    ) u_bank (
      .clk   (clk),
      .we    (wr_acc & wr_mask[k]),
      .waddr (wr_addr),
      .wdata (bank_wdata),
      .re    (rd_acc),
      .raddr (rd_addr),
      .rdata (bank_rdata)
    );
  end

  logic  s1_valid_q, s1_valid_d;
  logic  fwd_q, fwd_d;
  word_t fwd_data_q, fwd_data_d;
  logic  fwd_perr_q, fwd_perr_d;
  sel_t  sel_q, sel_d;

  always_comb begin
    s1_valid_d = 1'b0;
    fwd_d      = fwd_q;
    fwd_data_d = fwd_data_q;
    fwd_perr_d = fwd_perr_q;
    sel_d      = sel_q;
    if (rst_n) begin
      s1_valid_d = rd_en;
      if (rd_en) begin
        sel_d      = rd_word;
        fwd_d      = collide;
        fwd_data_d = wr_word;
        fwd_perr_d = (PARITY != 0) & wr_perr_inj;
      end
    end
  end

  always_ff @(posedge clk) begin
    s1_valid_q <= s1_valid_d;
    fwd_q      <= fwd_d;
    fwd_data_q <= fwd_data_d;
    fwd_perr_q <= fwd_perr_d;
    sel_q      <= sel_d;
  end

  word_t s1_word;
  logic  s1_perr;

  assign s1_word = fwd_q ? fwd_data_q : lane_data[sel_q];
  assign s1_perr = fwd_q ? fwd_perr_q : lane_perr[sel_q];

  if (RD_LAT == 1) begin : g_lat1
    // Bank and stage registers hold between reads; have_q masks them to zero
    // from reset until the first completed read.
    logic have_q, have_d;

    always_comb begin
      have_d = 1'b0;
      if (rst_n) have_d = have_q | s1_valid_q;
    end

    always_ff @(posedge clk) begin
      have_q <= have_d;
    end

    assign rd_valid = s1_valid_q;
    assign rd_data  = (have_q | s1_valid_q) ? s1_word : '0;
    assign rd_perr  = (have_q | s1_valid_q) ? s1_perr : 1'b0;
  end else begin : g_lat2
    logic  out_valid_q, out_valid_d;
    word_t out_data_q, out_data_d;
    logic  out_perr_q, out_perr_d;

    always_comb begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_perr_d  = 1'b0;
      if (rst_n) begin
        out_valid_d = s1_valid_q;
        out_data_d  = s1_valid_q ? s1_word : out_data_q;
        out_perr_d  = s1_valid_q ? s1_perr : out_perr_q;
      end
    end

    always_ff @(posedge clk) begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_perr_q  <= out_perr_d;
    end

    assign rd_valid = out_valid_q;
    assign rd_data  = out_data_q;
    assign rd_perr  = out_perr_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_ic_data_array.sv
`default_nettype none
// ============================================================================
// tb_ic_data_array -- directed + random checks of three array configurations
// Revision: 1.0
// ============================================================================
module tb_ic_data_array;

  logic        clk = 1'b0;
  logic        rst_n, rd_en, wr_en, wr_perr_inj;
  logic [1:0]  rd_way, rd_word, wr_way;
  logic [5:0]  rd_line, wr_line;
  logic [3:0]  wr_mask;
  logic [63:0] wr_data;

  logic [15:0] a_data, b_data, c_data;
  logic        a_valid, b_valid, c_valid;
  logic        a_perr, b_perr, c_perr;

  always #5 clk = ~clk;

  ic_data_array u_dut_a (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_way(rd_way), .rd_line(rd_line),
    .rd_word(rd_word), .rd_data(a_data), .rd_valid(a_valid), .rd_perr(a_perr),
    .wr_en(wr_en), .wr_way(wr_way), .wr_line(wr_line), .wr_mask(wr_mask),
    .wr_data(wr_data), .wr_perr_inj(wr_perr_inj)
  );

  ic_data_array #(.PARITY(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_way(rd_way), .rd_line(rd_line),
    .rd_word(rd_word), .rd_data(b_data), .rd_valid(b_valid), .rd_perr(b_perr),
    .wr_en(wr_en), .wr_way(wr_way), .wr_line(wr_line), .wr_mask(wr_mask),
    .wr_data(wr_data), .wr_perr_inj(wr_perr_inj)
  );

  ic_data_array #(.RD_LAT(2)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_way(rd_way), .rd_line(rd_line),
    .rd_word(rd_word), .rd_data(c_data), .rd_valid(c_valid), .rd_perr(c_perr),
    .wr_en(wr_en), .wr_way(wr_way), .wr_line(wr_line), .wr_mask(wr_mask),
    .wr_data(wr_data), .wr_perr_inj(wr_perr_inj)
  );

  // Reference model: word contents, injected-error flag, written flag.
  logic [15:0] m_data [4][64][4];
  bit          m_inj  [4][64][4];
  bit          m_wr   [4][64][4];

  // Expected outputs: 1-cycle view, 2-cycle view, and the read in flight.
  bit          e1_v, e1_p, e1_k, e2_v, e2_p, e2_k, pd_v, pd_p, pd_k;
  logic [15:0] e1_d, e2_d, pd_d;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit rst, input bit re, input int rway, input int rline,
                      input int rword, input bit we, input int wway, input int wline,
                      input bit [3:0] mask, input bit [63:0] data, input bit inj);
    bit          r_p, r_k;
    logic [15:0] r_d;
    rst_n = rst; rd_en = re; rd_way = 2'(rway); rd_line = 6'(rline); rd_word = 2'(rword);
    wr_en = we; wr_way = 2'(wway); wr_line = 6'(wline); wr_mask = mask;
    wr_data = data; wr_perr_inj = inj;
    @(posedge clk);
    if (!rst) begin
      {e1_v, e1_p, e2_v, e2_p, pd_v} = '0;
      e1_d = '0; e2_d = '0;
      e1_k = 1'b1; e2_k = 1'b1;
    end else begin
      r_d = '0; r_p = 1'b0; r_k = 1'b0;
      if (re) begin
        if (we && wway == rway && wline == rline && mask[rword]) begin
          r_d = data[rword*16 +: 16]; r_p = inj; r_k = 1'b1;
        end else begin
          r_d = m_data[rway][rline][rword];
          r_p = m_inj[rway][rline][rword];
          r_k = m_wr[rway][rline][rword];
        end
      end
      e2_v = pd_v;
      if (pd_v) begin e2_d = pd_d; e2_p = pd_p; e2_k = pd_k; end
      pd_v = re; pd_d = r_d; pd_p = r_p; pd_k = r_k;
      e1_v = re;
      if (re) begin e1_d = r_d; e1_p = r_p; e1_k = r_k; end
      if (we) begin
        for (int k = 0; k < 4; k++) begin
          if (mask[k]) begin
            m_data[wway][wline][k] = data[k*16 +: 16];
            m_inj[wway][wline][k]  = inj;
            m_wr[wway][wline][k]   = 1'b1;
          end
        end
      end
    end
    @(negedge clk);
    check("a_valid", 32'(a_valid), 32'(e1_v));
    check("b_valid", 32'(b_valid), 32'(e1_v));
    check("c_valid", 32'(c_valid), 32'(e2_v));
    check("b_perr",  32'(b_perr),  32'd0);
    if (e1_k) begin
      check("a_data", 32'(a_data), 32'(e1_d));
      check("a_perr", 32'(a_perr), 32'(e1_p));
      check("b_data", 32'(b_data), 32'(e1_d));
    end
    if (e2_k) begin
      check("c_data", 32'(c_data), 32'(e2_d));
      check("c_perr", 32'(c_perr), 32'(e2_p));
    end
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 64'h0, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(0, 1, 1, 5, 2, 1, 1, 5, 4'hF, 64'hFFFF, 0);
    check("rst_a_data", 32'(a_data), 32'd0);
    check("rst_c_valid", 32'(c_valid), 32'd0);
    idle();

    // Full fill then single read
    step(1, 0, 0, 0, 0, 1, 1, 5, 4'hF, 64'h4444_3333_2222_1111, 0);
    step(1, 1, 1, 5, 2, 0, 0, 0, 4'h0, 64'h0, 0);
    check("fill_rd_data", 32'(a_data), 32'h3333);
    check("fill_rd_valid", 32'(a_valid), 32'd1);
    check("fill_rd_perr", 32'(a_perr), 32'd0);
    idle();
    check("lat2_data", 32'(c_data), 32'h3333);
    check("lat1_idle_valid", 32'(a_valid), 32'd0);

    // Partial fill, back-to-back reads
    step(1, 0, 0, 0, 0, 1, 1, 5, 4'b0010, 64'h0000_0000_BEEF_0000, 0);
    step(1, 1, 1, 5, 0, 0, 0, 0, 4'h0, 64'h0, 0);
    check("b2b_word0", 32'(a_data), 32'h1111);
    step(1, 1, 1, 5, 1, 0, 0, 0, 4'h0, 64'h0, 0);
    check("b2b_word1", 32'(a_data), 32'hBEEF);

    // Same-cycle read/write collision
    step(1, 1, 1, 5, 3, 1, 1, 5, 4'b1000, 64'hCAFE_0000_0000_0000, 0);
    check("coll_fwd", 32'(a_data), 32'hCAFE);
    step(1, 1, 1, 5, 3, 1, 1, 5, 4'b0001, 64'h0000_0000_0000_DEAD, 0);
    check("coll_nofwd", 32'(a_data), 32'hCAFE);

    // Parity injection
    step(1, 0, 0, 0, 0, 1, 1, 5, 4'b0001, 64'h5A5A, 1);
    step(1, 1, 1, 5, 0, 0, 0, 0, 4'h0, 64'h0, 0);
    check("perr_inj", 32'(a_perr), 32'd1);
    check("perr_nopar", 32'(b_perr), 32'd0);
    step(1, 1, 3, 9, 2, 1, 3, 9, 4'b0100, 64'h0000_7777_0000_0000, 1);
    check("perr_fwd", 32'(a_perr), 32'd1);

    // Read in flight killed by reset; storage survives
    step(1, 0, 0, 0, 0, 1, 2, 7, 4'hF, 64'hD004_D003_D002_D001, 0);
    step(1, 1, 2, 7, 1, 0, 0, 0, 4'h0, 64'h0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 64'h0, 0);
    check("flight_killed", 32'(c_valid), 32'd0);
    idle();
    check("flight_gone", 32'(c_valid), 32'd0);
    step(1, 1, 2, 7, 3, 0, 0, 0, 4'h0, 64'h0, 0);
    idle();
    check("survive_data", 32'(c_data), 32'hD004);
    check("survive_valid", 32'(c_valid), 32'd1);

    // Randomised traffic over a small address window to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 50) != 0, $urandom % 2, $urandom % 4, $urandom % 4, $urandom % 4,
           ($urandom % 3) == 0, $urandom % 4, $urandom % 4, 4'($urandom),
           {$urandom, $urandom}, ($urandom % 8) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ic_data_array.md
IC_DATA_ARRAY -- requirements
Module: ic_data_array

Interface
REQ-001 The block SHALL have parameter WAYS, default 4, number of ways (power of two, >=2).
REQ-002 The block SHALL have parameter LINES, default 64, number of lines per way (power of two, >=2).
REQ-003 The block SHALL have parameter WORDS, default 4, number of words per line (power of two, >=2).
REQ-004 The block SHALL have parameter WORD_W, default 16, bits per word.
REQ-005 The block SHALL have parameter RD_LAT, default 1, read latency in cycles (1 or 2).
REQ-006 The block SHALL have parameter PARITY, default 1, enabling per-word even parity storage and checking.
REQ-007 clk  input  1  clock; all logic on posedge.
REQ-008 rst_n  input  1  reset, synchronous, active-low.
REQ-009 rd_en  input  1  read request.
REQ-010 rd_way / rd_line / rd_word  input  clog2(WAYS) / clog2(LINES) / clog2(WORDS)  read address.
REQ-011 rd_data  output  WORD_W  read word.
REQ-012 rd_valid  output  1  rd_data/rd_perr valid this cycle.
REQ-013 rd_perr  output  1  parity error on returned word.
REQ-014 wr_en  input  1  fill write.
REQ-015 wr_way / wr_line  input  clog2(WAYS) / clog2(LINES)  fill address.
REQ-016 wr_mask  input  WORDS  per-word write enable; bit k writes word k.
REQ-017 wr_data  input  WORDS*WORD_W  fill data; word k in bits [k*WORD_W +: WORD_W].
REQ-018 wr_perr_inj  input  1  invert stored parity of words written this cycle (test only).

Function
REQ-019 Storage SHALL be WAYS*LINES entries of WORDS words, indexed {line,way}.
REQ-020 On wr_en, each word k with wr_mask[k]=1 SHALL be written at the posedge; unmasked words unchanged; wr_en with wr_mask=0 is a no-op.
REQ-021 A read accepted at cycle N (rd_en=1) SHALL present rd_data and rd_valid=1 at cycle N+RD_LAT; throughput one read per cycle, no stalls.
REQ-022 rd_valid SHALL be 0 in every cycle with no matching accepted read; rd_data and rd_perr hold their last value then.
REQ-023 Collision: rd_en and wr_en in the same cycle with equal way, equal line and wr_mask[rd_word]=1 SHALL return the new wr_data word (write-first).
REQ-024 Same line/way with wr_mask[rd_word]=0, or different way/line, SHALL return the previously stored word.
REQ-025 Parity: with PARITY=1 each word stores one even-parity bit (XOR of data, inverted when wr_perr_inj=1); rd_perr=1 when recomputed parity mismatches stored.
REQ-026 Forwarded collision data SHALL report rd_perr equal to wr_perr_inj of the colliding write.
REQ-027 With PARITY=0 no parity bits stored and rd_perr SHALL be constant 0.
REQ-028 With RD_LAT=2 the second stage SHALL be a plain output register; collision detection uses the accept cycle only.
REQ-029 Contents of never-written words are undefined; rd_perr on them is don't-care.

Reset
REQ-030 While rst_n=0: rd_valid=0, rd_perr=0, rd_data=0, all pipeline valid bits cleared, rd_en and wr_en ignored.
REQ-031 Storage contents SHALL NOT be reset and SHALL survive reset.
REQ-032 Reads in flight when rst_n falls SHALL be discarded; no rd_valid for them after reset release.
REQ-033 First read accepted in the cycle after rst_n rises SHALL complete normally.

Structure
REQ-034 ic_pkg SHALL hold the IMPL selector enum and default-geometry constants; width typedefs derived locally from parameters.
REQ-035 One sub-module ic_ram_bank SHALL implement a simple dual-port WORD_W+PARITY-bit bank (one write, one registered read), instantiated WORDS times, one per word lane.
REQ-036 Illegal parameters (non-power-of-two, RD_LAT not 1/2) SHALL raise an elaboration $error.

Verification
REQ-037 Defaults: fill way1 line5 mask 4'hF words 16'h1111..16'h4444; read way1 line5 word2 -> next cycle rd_valid=1, rd_data=16'h3333, rd_perr=0.
REQ-038 Partial fill mask 4'b0010 word1=16'hBEEF to same entry; read words 0,1 back-to-back -> 16'h1111 then 16'hBEEF on consecutive cycles.
REQ-039 Same-cycle read way1 line5 word3 with write mask 4'b1000 data 16'hCAFE -> rd_data=16'hCAFE; repeat with mask 4'b0001 -> old word3 returned.
REQ-040 Write word0 with wr_perr_inj=1, read it -> rd_perr=1; PARITY=0 build, same stimulus -> rd_perr=0.
REQ-041 RD_LAT=2: read at N -> rd_valid only at N+2; assert rst_n=0 at N+1 -> no rd_valid, data written before reset still readable after.
